midori_sbox_layer_masked: RTL

- Parametrised, pipelined layer of NUM_SBOX second-order (3-share) masked Midori Sb0 S-boxes. Generalises the single-instance masked S-box.
- Adds a valid/enable pipeline, a synchronous reset, and cross-lane recycling of stored input shares as refresh randomness.
- Sits between the masked state register and the MixColumn/key-add path of the masked Midori datapath.

---
 rtl/midori_mask_pkg.sv | 42 ++++
 rtl/F_2order.sv | 59 +++++
 rtl/G_2order.sv | 58 +++++
 rtl/masked_sbox_lane.sv | 66 ++++++
 rtl/midori_sbox_layer_masked.sv | 69 ++++++
 5 files changed

// File: rtl/midori_mask_pkg.sv
// Shared constants, share-vector type and masking gadgets for the 3-share
// masked Midori Sb0 datapath.
package midori_mask_pkg;

    localparam int unsigned SBOX_W   = 4;
    localparam int unsigned NSHARES  = 3;
    localparam int unsigned F_RAND_W = 27;
    localparam int unsigned G_RAND_W = 18;
    localparam int unsigned RS_W     = 6;
    // F stage carries x0..x3 plus x0x1, x2x3, x0x2, x0x3, x1x3
    localparam int unsigned F_OUT_W  = 9;

    localparam logic [3:0] SB0 [16] = '{
        4'hC, 4'hA, 4'hD, 4'h3, 4'hE, 4'hB, 4'hF, 4'h7,
        4'h8, 4'h9, 4'h1, 4'h5, 4'h0, 4'h2, 4'h4, 4'h6
    };

    // One logical bit held as three shares, bit n = share n+1
    typedef logic [NSHARES-1:0] shr_t;

    function automatic int unsigned nib_lo(input int unsigned lane);
        return lane * SBOX_W;
    endfunction

    function automatic int unsigned rnd_lo(input int unsigned lane, input int unsigned per_lane);
        return lane * per_lane;
    endfunction

    // Domain-oriented AND: every cross-domain term is blinded by a fresh bit
    function automatic shr_t dom_and(input shr_t a, input shr_t b, input logic [2:0] r);
        shr_t z;
        z[0] = (a[0] & b[0]) ^ ((a[0] & b[1]) ^ r[0]) ^ ((a[0] & b[2]) ^ r[1]);
        z[1] = (a[1] & b[1]) ^ ((a[1] & b[0]) ^ r[0]) ^ ((a[1] & b[2]) ^ r[2]);
        z[2] = (a[2] & b[2]) ^ ((a[2] & b[0]) ^ r[1]) ^ ((a[2] & b[1]) ^ r[2]);
        return z;
    endfunction

    function automatic shr_t refresh3(input shr_t a, input logic [2:0] r);
        return a ^ {r[2] ^ r[1], r[1] ^ r[0], r[0] ^ r[2]};
    endfunction

endpackage

// File: rtl/F_2order.sv
// First quadratic stage of masked Sb0: refreshed linear bits plus the five
// degree-2 monomials, registered per share.
module F_2order
    import midori_mask_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic [SBOX_W-1:0]   sh1,
    input  logic [SBOX_W-1:0]   sh2,
    input  logic [SBOX_W-1:0]   sh3,
    input  logic [F_RAND_W-1:0] rnd,
    input  logic [RS_W-1:0]     rs,
    output logic [F_OUT_W-1:0]  out_sh1,
    output logic [F_OUT_W-1:0]  out_sh2,
    output logic [F_OUT_W-1:0]  out_sh3
);

    localparam int unsigned LIN_RND_LO = 15;

    shr_t               x [SBOX_W];
    shr_t               f [F_OUT_W];
    logic [F_OUT_W-1:0] d1, d2, d3;

    always_comb begin
        for (int unsigned k = 0; k < SBOX_W; k++) begin
            x[k] = {sh3[k], sh2[k], sh1[k]};
            f[k] = refresh3(x[k], rnd[LIN_RND_LO + 3*k +: 3]);
        end
        f[4] = dom_and(x[0], x[1], rnd[2:0]);
        f[5] = dom_and(x[2], x[3], rnd[5:3]);
        f[6] = dom_and(x[0], x[2], rnd[8:6]);
        f[7] = dom_and(x[0], x[3], rnd[11:9]);
        f[8] = dom_and(x[1], x[3], rnd[14:12]);
        for (int unsigned j = 0; j < F_OUT_W; j++) begin
            d1[j] = f[j][0];
            d2[j] = f[j][1];
            d3[j] = f[j][2];
        end
        // Recycled bits enter two shares of the same value, so they cancel
        for (int unsigned m = 0; m < RS_W; m++) begin
            d1[m] = d1[m] ^ rs[m];
            d2[m] = d2[m] ^ rs[m];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_sh1 <= '0;
            out_sh2 <= '0;
            out_sh3 <= '0;
        end else if (en) begin
            out_sh1 <= d1;
            out_sh2 <= d2;
            out_sh3 <= d3;
        end
    end

endmodule

// File: rtl/G_2order.sv
// Second quadratic stage of masked Sb0: forms the three cubic terms and
// recombines everything into the four output bits, registered per share.
module G_2order
    import midori_mask_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic [F_OUT_W-1:0]  sh1,
    input  logic [F_OUT_W-1:0]  sh2,
    input  logic [F_OUT_W-1:0]  sh3,
    input  logic [G_RAND_W-1:0] rnd,
    input  logic [RS_W-1:0]     rs,
    output logic [SBOX_W-1:0]   out_sh1,
    output logic [SBOX_W-1:0]   out_sh2,
    output logic [SBOX_W-1:0]   out_sh3
);

    localparam shr_t ONE = 3'b001;

    shr_t              v [F_OUT_W];
    shr_t              y [SBOX_W];
    shr_t              c0, c1, c2;
    logic [SBOX_W-1:0] d1, d2, d3;

    always_comb begin
        for (int unsigned j = 0; j < F_OUT_W; j++) v[j] = {sh3[j], sh2[j], sh1[j]};
        c0 = dom_and(v[4], v[2], rnd[2:0]);   // x0x1x2
        c1 = dom_and(v[4], v[3], rnd[5:3]);   // x0x1x3
        c2 = dom_and(v[1], v[5], rnd[8:6]);   // x1x2x3
        y[0] = v[1] ^ v[6] ^ v[7] ^ c0 ^ c1 ^ c2;
        y[1] = refresh3(v[0] ^ v[2] ^ v[6] ^ v[7] ^ v[5], rnd[11:9]);
        y[2] = refresh3(v[0] ^ v[3] ^ v[7] ^ c0 ^ c1 ^ c2 ^ ONE, rnd[14:12]);
        y[3] = refresh3(v[4] ^ v[8] ^ v[5] ^ c1 ^ c2 ^ ONE, rnd[17:15]);
        for (int unsigned k = 0; k < SBOX_W; k++) begin
            d1[k] = y[k][0] ^ rs[k];
            d2[k] = y[k][1] ^ rs[k];
            d3[k] = y[k][2];
        end
        for (int unsigned m = 0; m < RS_W - SBOX_W; m++) begin
            d2[m] = d2[m] ^ rs[SBOX_W + m];
            d3[m] = d3[m] ^ rs[SBOX_W + m];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_sh1 <= '0;
            out_sh2 <= '0;
            out_sh3 <= '0;
        end else if (en) begin
            out_sh1 <= d1;
            out_sh2 <= d2;
            out_sh3 <= d3;
        end
    end

endmodule

// File: rtl/masked_sbox_lane.sv
// One 3-share masked Sb0 lane: input register, recycled-share register,
// then the F and G stages.
module masked_sbox_lane
    import midori_mask_pkg::*;
(
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         en,
    input  logic [SBOX_W-1:0]            sh1,
    input  logic [SBOX_W-1:0]            sh2,
    input  logic [SBOX_W-1:0]            sh3,
    input  logic [F_RAND_W+G_RAND_W-1:0] rnd,
    input  logic [RS_W-1:0]              rs_in,
    output logic [SBOX_W-1:0]            out_sh1,
    output logic [SBOX_W-1:0]            out_sh2,
    output logic [SBOX_W-1:0]            out_sh3,
    output logic [RS_W-1:0]              rs_out
);

    logic [SBOX_W-1:0]  a1, a2, a3;
    logic [F_OUT_W-1:0] f1, f2, f3;

    // The chosen F/G split of Sb0 needs an identity input affine map
    always_ff @(posedge clk) begin
        if (rst) begin
            a1     <= '0;
            a2     <= '0;
            a3     <= '0;
            rs_out <= '0;
        end else if (en) begin
            a1     <= sh1;
            a2     <= sh2;
            a3     <= sh3;
            rs_out <= {sh2[1:0], sh1};
        end
    end

    F_2order u_f (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .sh1     (a1),
        .sh2     (a2),
        .sh3     (a3),
        .rnd     (rnd[F_RAND_W-1:0]),
        .rs      (rs_in),
        .out_sh1 (f1),
        .out_sh2 (f2),
        .out_sh3 (f3)
    );

    G_2order u_g (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .sh1     (f1),
        .sh2     (f2),
        .sh3     (f3),
        .rnd     (rnd[F_RAND_W +: G_RAND_W]),
        .rs      ('0),
        .out_sh1 (out_sh1),
        .out_sh2 (out_sh2),
        .out_sh3 (out_sh3)
    );

endmodule

// File: rtl/midori_sbox_layer_masked.sv
// Layer of NUM_SBOX masked Sb0 lanes with a 3-deep valid pipeline and a
// lane-to-lane chain of recycled input shares.
module midori_sbox_layer_masked
    import midori_mask_pkg::SBOX_W, midori_mask_pkg::F_RAND_W, midori_mask_pkg::G_RAND_W,
           midori_mask_pkg::nib_lo, midori_mask_pkg::rnd_lo;
#(
    parameter int unsigned NUM_SBOX      = 16,
    parameter int unsigned RAND_PER_LANE = 45,
    parameter int unsigned RS_W          = 6
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              en,
    input  logic                              in_valid,
    input  logic [SBOX_W*NUM_SBOX-1:0]        in_sh1,
    input  logic [SBOX_W*NUM_SBOX-1:0]        in_sh2,
    input  logic [SBOX_W*NUM_SBOX-1:0]        in_sh3,
    input  logic [RAND_PER_LANE*NUM_SBOX-1:0] rnd,
    input  logic [RS_W-1:0]                   rs_seed,
    output logic                              out_valid,
    output logic [SBOX_W*NUM_SBOX-1:0]        out_sh1,
    output logic [SBOX_W*NUM_SBOX-1:0]        out_sh2,
    output logic [SBOX_W*NUM_SBOX-1:0]        out_sh3,
    output logic [RS_W-1:0]                   rs_tail
);

    if (NUM_SBOX < 1 || NUM_SBOX > 16) begin : g_num_chk
        $error("NUM_SBOX must be within 1..16");
    end
    if (RAND_PER_LANE != F_RAND_W + G_RAND_W) begin : g_rnd_chk
        $error("RAND_PER_LANE must equal F_RAND_W + G_RAND_W");
    end
    if (RS_W != midori_mask_pkg::RS_W) begin : g_rs_chk
        $error("RS_W must match the lane recycled-share width");
    end

    logic [2:0]                   v;
    logic [NUM_SBOX:0][RS_W-1:0] rs_chain;

    always_ff @(posedge clk) begin
        if (rst) begin
            v <= '0;
        end else if (en) begin
            v <= {v[1:0], in_valid};
        end
    end

    assign out_valid   = v[2];
    assign rs_chain[0] = rs_seed;
    assign rs_tail     = rs_chain[NUM_SBOX];

    for (genvar i = 0; i < NUM_SBOX; i++) begin : g_lane
        masked_sbox_lane u_lane (
            .clk     (clk),
            .rst     (rst),
            .en      (en),
            .sh1     (in_sh1[nib_lo(i) +: SBOX_W]),
            .sh2     (in_sh2[nib_lo(i) +: SBOX_W]),
            .sh3     (in_sh3[nib_lo(i) +: SBOX_W]),
            .rnd     (rnd[rnd_lo(i, RAND_PER_LANE) +: RAND_PER_LANE]),
            .rs_in   (rs_chain[i]),
            .out_sh1 (out_sh1[nib_lo(i) +: SBOX_W]),
            .out_sh2 (out_sh2[nib_lo(i) +: SBOX_W]),
            .out_sh3 (out_sh3[nib_lo(i) +: SBOX_W]),
            .rs_out  (rs_chain[i+1])
        );
    end

endmodule
